// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal transmit FIFO.
// Frames are start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Each bit lasts DIV = CLK_HZ/BAUD clocks.
// Optional feature: define UART_PARITY_EN to insert a parity bit after the data bits.
// PARITY_ODD selects the parity sense (0 = even, 1 = odd).
module uart_tx_fifo #(
  parameter int unsigned CLK_HZ     = 10000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          ovf_clr,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          overflow,
  output logic                          irq,
  output logic                          tx
);

  localparam int unsigned Div  = CLK_HZ / BAUD;
  localparam int unsigned CntW = $clog2(Div);
  localparam int unsigned BitW = $clog2(DATA_BITS);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  // Elaboration-time parameter legality checks.
  if (Div < 2) begin : g_bad_div
    $error("uart_tx_fifo: CLK_HZ/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
  end

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]       level_q, level_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  ovf_q, ovf_d;
  logic                  busy_q, irq_q, tx_q, tx_d;
  logic                  push, pop, cnt_last;
`ifdef UART_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  assign cnt_last = (cnt_q == CntW'(Div - 1));

  // FIFO occupancy and sticky overflow; a pop never frees room for a same-cycle write.
  always_comb begin
    push    = wr_en & ~full_q;
    level_d = level_q + LvlW'(push) - LvlW'(pop);
    full_d  = (level_d == LvlW'(FIFO_DEPTH));
    empty_d = (level_d == '0);
    ovf_d   = ovf_q;
    if (wr_en && full_q) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Frame sequencer: each state lasts Div clocks; STOP chains straight into the next word.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop      = 1'b0;
`ifdef UART_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!empty_q) begin
          pop      = 1'b1;
          state_d  = StStart;
          cnt_d    = '0;
          shift_d  = mem_q[rd_ptr_q];
`ifdef UART_PARITY_EN
          parity_d = (^mem_q[rd_ptr_q]) ^ PARITY_ODD[0];
`endif
        end
      end
      StStart: begin
        if (cnt_last) begin
          state_d = StData;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_last) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BitW'(DATA_BITS - 1)) begin
            bit_d   = '0;
`ifdef UART_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        if (cnt_last) begin
          state_d = StStop;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      StStop: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_q == BitW'(STOP_BITS - 1)) begin
            bit_d = '0;
            if (!empty_q) begin
              pop      = 1'b1;
              state_d  = StStart;
              shift_d  = mem_q[rd_ptr_q];
`ifdef UART_PARITY_EN
              parity_d = (^mem_q[rd_ptr_q]) ^ PARITY_ODD[0];
`endif
            end else begin
              state_d = StIdle;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level for the upcoming cycle, derived from the next state so tx is a clean flop.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef UART_PARITY_EN
      StParity: tx_d = parity_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // FIFO storage; not reset, contents are only read behind a valid level.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // State, pointers and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      irq_q    <= 1'b1;
      tx_q     <= 1'b1;
`ifdef UART_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      busy_q   <= (state_d != StIdle);
      irq_q    <= empty_d & (state_d == StIdle);
      tx_q     <= tx_d;
`ifdef UART_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;
  assign irq      = irq_q;
  assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus random traffic, every
// cycle compared against a timestamp-based frame model.
module tb_uart_tx_fifo;

  localparam int unsigned ClkHz     = 10000000;
  localparam int unsigned Baud      = 1000000;
  localparam int unsigned Div       = ClkHz / Baud;
  localparam int unsigned DataBits  = 8;
  localparam int unsigned Depth     = 16;
  localparam int unsigned ParityOdd = 0;
`ifdef UART_PARITY_EN
  localparam int unsigned ParBits   = 1;
`else
  localparam int unsigned ParBits   = 0;
`endif
  localparam int unsigned Frame     = (1 + DataBits + ParBits + 1) * Div;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       ovf_clr;
  logic       full, empty, busy, overflow, irq, tx;
  logic [4:0] level;

  uart_tx_fifo #(
    .CLK_HZ    (ClkHz),
    .BAUD      (Baud),
    .DATA_BITS (DataBits),
    .STOP_BITS (1),
    .FIFO_DEPTH(Depth),
    .PARITY_ODD(ParityOdd)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .ovf_clr (ovf_clr),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .busy    (busy),
    .overflow(overflow),
    .irq     (irq),
    .tx      (tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: FIFO contents as a queue, active frame as a launch timestamp.
  int unsigned cyc      = 0;
  bit          model_ok = 1'b0;
  logic [7:0]  q[$];
  bit          active   = 1'b0;
  int unsigned launch   = 0;
  logic [7:0]  cur      = '0;
  bit          ovf      = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Line value within a frame, by bit slot: start, data LSB first, [parity], stop.
  function automatic logic frame_bit(input logic [7:0] w, input int unsigned slot);
    if (slot == 0) return 1'b0;
    if (slot <= DataBits) return w[slot-1];
    if (ParBits == 1 && slot == DataBits + 1) return (^w) ^ ParityOdd[0];
    return 1'b1;
  endfunction

  task automatic model_step(input logic w, input logic [7:0] d, input logic c, input logic r);
    int unsigned sz;
    cyc++;
    if (!r) begin
      q.delete();
      active   = 1'b0;
      ovf      = 1'b0;
      model_ok = 1'b1;
      return;
    end
    if (!model_ok) return;
    sz = q.size();
    if (!active) begin
      if (sz > 0) begin
        cur    = q.pop_front();
        active = 1'b1;
        launch = cyc;
      end
    end else if (cyc - launch == Frame) begin
      if (sz > 0) begin
        cur    = q.pop_front();
        launch = cyc;
      end else begin
        active = 1'b0;
      end
    end
    if (w && sz == Depth) begin
      ovf = 1'b1;
    end else begin
      if (w) q.push_back(d);
      if (c) ovf = 1'b0;
    end
  endtask

  task automatic check_all();
    logic exp_tx;
    exp_tx = active ? frame_bit(cur, (cyc - launch) / Div) : 1'b1;
    check_eq("tx", 32'(tx), 32'(exp_tx));
    check_eq("busy", 32'(busy), 32'(active));
    check_eq("irq", 32'(irq), 32'((q.size() == 0) && !active));
    check_eq("empty", 32'(empty), 32'(q.size() == 0));
    check_eq("full", 32'(full), 32'(q.size() == Depth));
    check_eq("level", 32'(level), 32'(q.size()));
    check_eq("overflow", 32'(overflow), 32'(ovf));
  endtask

  // One clock: drive at negedge, model at posedge, compare at the following negedge.
  task automatic step(input logic w, input logic [7:0] d, input logic c, input logic r);
    wr_en   = w;
    wr_data = d;
    ovf_clr = c;
    rst     = r;
    @(posedge clk);
    model_step(w, d, c, r);
    @(negedge clk);
    if (model_ok) check_all();
  endtask

  task automatic idle(input int unsigned n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    int unsigned rate;
    rst     = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    ovf_clr = 1'b0;
    @(negedge clk);

    // Reset state.
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_irq", 32'(irq), 32'd1);
    idle(3);

    // Single frame 0xA5.
    step(1'b1, 8'hA5, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("a5_start", 32'(tx), 32'd0);
    idle(Frame + 10);
    check_eq("a5_done_busy", 32'(busy), 32'd0);

    // Back-to-back frames 0x00 then 0xFF.
    step(1'b1, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'hFF, 1'b0, 1'b1);
    idle(2 * Frame + 10);

    // Fill to full while the first frame is still in flight, then overflow handling.
    for (int i = 0; i < 17; i++) step(1'b1, 8'(i * 7 + 3), 1'b0, 1'b1);
    check_eq("fill_level", 32'(level), 32'd16);
    check_eq("fill_full", 32'(full), 32'd1);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    check_eq("ovf_set", 32'(overflow), 32'd1);
    check_eq("ovf_level", 32'(level), 32'd16);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    check_eq("ovf_clr", 32'(overflow), 32'd0);
    step(1'b1, 8'h11, 1'b1, 1'b1);
    check_eq("ovf_set_wins", 32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    idle(3 * Frame);

    // Reset mid-DATA with three words queued.
    step(1'b0, 8'h00, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 8'h3C, 1'b0, 1'b1);
    step(1'b1, 8'h81, 1'b0, 1'b1);
    step(1'b1, 8'h42, 1'b0, 1'b1);
    step(1'b1, 8'h99, 1'b0, 1'b1);
    idle(40);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("mid_rst_tx", 32'(tx), 32'd1);
    check_eq("mid_rst_level", 32'(level), 32'd0);
    idle(Frame + 20);

    // Random traffic with varying write density, clears and rare resets.
    for (int blk = 0; blk < 8; blk++) begin
      rate = $urandom_range(1, 150);
      for (int i = 0; i < 400; i++) begin
        step($urandom_range(0, rate) == 0, 8'($urandom), $urandom_range(0, 40) == 0,
             $urandom_range(0, 1500) != 0);
      end
    end
    idle(Depth * Frame + 20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an internal transmit FIFO. Software or a bus bridge pushes words into the FIFO, and the block serialises them as 8N1-style frames (configurable data bits and stop bits) at a fixed baud rate derived from the system clock. It supersedes the single-word transmitter on the SoC peripheral bus and adds queuing, an overflow flag and a tx-empty interrupt.

Parameters:
CLK_HZ, 10000000, system clock frequency in Hz
BAUD, 9600, line rate in bits/s; DIV = CLK_HZ/BAUD (integer, truncated), DIV >= 2 required
DATA_BITS, 8, data bits per frame, legal 5..9
STOP_BITS, 1, stop bits per frame, legal 1 or 2
FIFO_DEPTH, 16, FIFO entries, power of 2, >= 2
PARITY_ODD, 0, parity sense when UART_PARITY_EN is defined (0 = even, 1 = odd)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low
wr_en  input  1  push wr_data into FIFO this cycle
wr_data  input  DATA_BITS  word to transmit
ovf_clr  input  1  clears the overflow flag
full  output  1  FIFO holds FIFO_DEPTH words
empty  output  1  FIFO holds 0 words
level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
busy  output  1  frame in progress
overflow  output  1  sticky; a write was dropped
irq  output  1  level interrupt, high when empty=1 and busy=0
tx  output  1  serial line, idle high

Behaviour:
- Reset (rst=0 at a clock edge): tx=1, busy=0, FIFO flushed (empty=1, full=0, level=0), overflow=0, irq=1, FSM=IDLE, baud counter=0. Reset mid-frame aborts the frame; tx is high from the next edge.
- FIFO write: accepted only if full=0 at that edge. A same-cycle pop does not make room for a write when full=1. A write while full is dropped and sets overflow=1.
- overflow: stays set until ovf_clr=1 or reset. If ovf_clr and a dropped write occur in the same cycle, overflow stays 1 (set wins).
- level/full/empty: registered and updated on the same edge as the push or pop. Simultaneous push and pop with 0 < level < FIFO_DEPTH leaves level unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE: if empty=0, pop the head into the shift register, go to START, drive tx=0, busy=1, and clear the baud counter. A word written into an empty FIFO at edge N launches at edge N+1.
- Each state holds for exactly DIV clocks. The baud counter runs 0..DIV-1; the state advances when the counter reaches DIV-1.
- DATA: sends DATA_BITS bits LSB first, one bit per DIV clocks.
- STOP: tx=1 for STOP_BITS*DIV clocks. On the final stop-bit clock, if empty=0 the next word is popped and START begins on the following edge (no idle gap). Otherwise go to IDLE and set busy=0.
- Frame length: (1 + DATA_BITS + P + STOP_BITS) * DIV clocks, where P = 1 with the macro and 0 without.
- wr_data bits above DATA_BITS do not exist; width is exact.
- irq = empty & ~busy, registered alongside busy.

Optional Feature:
UART_PARITY_EN
- Defined: a PARITY state follows DATA for DIV clocks. tx = XOR of the data bits, inverted when PARITY_ODD=1.
- Undefined: there is no PARITY state and DATA goes directly to STOP. PARITY_ODD is ignored.

Test Plan:
- Common setup for all scenarios: CLK_HZ=10000000, BAUD=1000000 (DIV=10), DATA_BITS=8, STOP_BITS=1, macro off.
- Reset, then write 0xA5 -> tx low one edge later. tx then holds each of 0,1,0,1,0,0,1,0,1,1 for 10 clocks. busy=0 and irq=1 after 100 clocks.
- Write 0x00 and 0xFF on consecutive cycles -> two frames back to back with no idle gap (tx 1 for exactly 10 clocks between the 0x00 data and the 0xFF start). irq stays 0 until the end of the second frame.
- Write 17 words while tx is stalled at the first frame (FIFO_DEPTH=16) -> the first pops immediately and 16 queue. full=1, level=16. Then one more write -> overflow=1 and level stays 16. Pulse ovf_clr -> overflow=0.
- Assert rst=0 mid-DATA of 0x3C with 3 words queued -> next edge tx=1, busy=0, empty=1, level=0, irq=1. No further frames after rst=1.
- With UART_PARITY_EN, PARITY_ODD=0, write 0x07 -> parity bit = 1 and frame = 110 clocks. With PARITY_ODD=1 -> parity bit = 0.
